// File: rtl/id_stage_fwd.sv
// rtl/id_stage_fwd.sv - decode-stage front end: IF/ID register, instruction hold, forwarding, hazards, branch resolve
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   stall[5:0], flush     pipeline stall vector (bit1 IF/ID, bit2 ID), kill of ID contents
//   if_valid, if_pc       IF output
//   inst_sram_rdata       instruction word, one cycle behind its PC
//   rf_raddr1/2, rf_rdata1/2   external regfile read port (rs, rt)
//   fwd_we/waddr/wdata/pend    packed bypass sources, index 0 youngest
//   stallreq              hazard stall request
//   id_valid/pc/inst      ID stage contents
//   id_rs_val/id_rt_val   forwarded operands
//   br_e, br_addr         taken branch/jump and redirect target
module id_stage_fwd #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 3,
    parameter int RA_W    = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              stall,
    input  logic                    flush,
    input  logic                    if_valid,
    input  logic [XLEN-1:0]         if_pc,
    input  logic [31:0]             inst_sram_rdata,
    output logic [RA_W-1:0]         rf_raddr1,
    output logic [RA_W-1:0]         rf_raddr2,
    input  logic [XLEN-1:0]         rf_rdata1,
    input  logic [XLEN-1:0]         rf_rdata2,
    input  logic [NUM_FWD-1:0]      fwd_we,
    input  logic [NUM_FWD*RA_W-1:0] fwd_waddr,
    input  logic [NUM_FWD*XLEN-1:0] fwd_wdata,
    input  logic [NUM_FWD-1:0]      fwd_pend,
    output logic                    stallreq,
    output logic                    id_valid,
    output logic [XLEN-1:0]         id_pc,
    output logic [31:0]             id_inst,
    output logic [XLEN-1:0]         id_rs_val,
    output logic [XLEN-1:0]         id_rt_val,
    output logic                    br_e,
    output logic [XLEN-1:0]         br_addr
);

    typedef enum logic {RUN, HOLD} state_t;

    state_t          state, state_nx;
    logic            capture;
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     hold_inst;

    // Only the IF/ID and ID bits of the stall vector matter here.
    logic unused_stall;
    assign unused_stall = ^{stall[5:3], stall[0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (stall[1] && !stall[2]) begin
            valid <= 1'b0;
        end else if (!stall[1]) begin
            valid <= if_valid;
            pc    <= if_pc;
        end
    end

    // The SRAM output follows whatever address IF presents next, so the
    // word must be latched on the first stalled edge to survive the stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            hold_inst <= '0;
        end else begin
            state <= state_nx;
            if (capture) hold_inst <= inst_sram_rdata;
        end
    end

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        case (state)
            RUN: begin
                if (stall[2] && valid && !flush) begin
                    state_nx = HOLD;
                    capture  = 1'b1;
                end
            end
            HOLD: begin
                if (flush || !stall[2]) state_nx = RUN;
            end
            default: state_nx = RUN;
        endcase
    end

    assign id_valid = valid;
    assign id_pc    = pc;
    assign id_inst  = !valid ? 32'd0 : ((state == HOLD) ? hold_inst : inst_sram_rdata);

    logic [RA_W-1:0] rs_addr, rt_addr;
    assign rs_addr   = RA_W'(id_inst[25:21]);
    assign rt_addr   = RA_W'(id_inst[20:16]);
    assign rf_raddr1 = rs_addr;
    assign rf_raddr2 = rt_addr;

    // Walk oldest to youngest so the lowest-index match is the last writer.
    // The pending flag travels with the winner, so a ready younger result
    // hides an older load still in flight.
    logic rs_pend, rt_pend;
    always_comb begin
        id_rs_val = rf_rdata1;
        id_rt_val = rf_rdata2;
        rs_pend   = 1'b0;
        rt_pend   = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_we[i] && fwd_waddr[i*RA_W +: RA_W] == rs_addr) begin
                id_rs_val = fwd_wdata[i*XLEN +: XLEN];
                rs_pend   = fwd_pend[i];
            end
            if (fwd_we[i] && fwd_waddr[i*RA_W +: RA_W] == rt_addr) begin
                id_rt_val = fwd_wdata[i*XLEN +: XLEN];
                rt_pend   = fwd_pend[i];
            end
        end
        if (rs_addr == '0) begin
            id_rs_val = '0;
            rs_pend   = 1'b0;
        end
        if (rt_addr == '0) begin
            id_rt_val = '0;
            rt_pend   = 1'b0;
        end
    end

    logic [5:0] op, funct;
    logic is_r, is_j, is_jal, is_beq, is_bne, is_lui, is_store, is_shimm, is_jr, is_jalr;
    logic use_rs, use_rt;
    assign op       = id_inst[31:26];
    assign funct    = id_inst[5:0];
    assign is_r     = (op == 6'h00);
    assign is_j     = (op == 6'h02);
    assign is_jal   = (op == 6'h03);
    assign is_beq   = (op == 6'h04);
    assign is_bne   = (op == 6'h05);
    assign is_lui   = (op == 6'h0F);
    assign is_store = (op == 6'h28) || (op == 6'h29) || (op == 6'h2A) ||
                      (op == 6'h2B) || (op == 6'h2E);
    assign is_shimm = is_r && ((funct == 6'h00) || (funct == 6'h02) || (funct == 6'h03));
    assign is_jr    = is_r && (funct == 6'h08);
    assign is_jalr  = is_r && (funct == 6'h09);
    assign use_rs   = !(is_j || is_jal || is_shimm || is_lui);
    assign use_rt   = is_r || is_beq || is_bne || is_store;

    assign stallreq = valid && ((use_rs && rs_pend) || (use_rt && rt_pend));

    logic [XLEN-1:0] pc_plus4, br_tgt, j_tgt, target;
    logic            taken;
    assign pc_plus4 = pc + XLEN'(4);
    assign br_tgt   = pc_plus4 + {{(XLEN-18){id_inst[15]}}, id_inst[15:0], 2'b00};
    assign j_tgt    = {pc_plus4[XLEN-1:28], id_inst[25:0], 2'b00};

    always_comb begin
        taken  = 1'b0;
        target = '0;
        if (is_beq) begin
            taken  = (id_rs_val == id_rt_val);
            target = br_tgt;
        end else if (is_bne) begin
            taken  = (id_rs_val != id_rt_val);
            target = br_tgt;
        end else if (is_j || is_jal) begin
            taken  = 1'b1;
            target = j_tgt;
        end else if (is_jr || is_jalr) begin
            taken  = 1'b1;
            target = id_rs_val;
        end
    end

    assign br_e    = valid && !stallreq && taken;
    assign br_addr = br_e ? target : '0;

endmodule

// File: doc/id_stage_fwd.md
Name: id_stage_fwd

Overview:
- Parametrised decode-stage front end. Holds the IF->ID pipeline register and keeps the synchronous-SRAM instruction word stable across stalls.
- Selects operands from a configurable number of forwarding sources, with priority.
- Detects load-use and branch-operand hazards and raises a stall request.
- Resolves beq/bne/j/jal/jr/jalr in ID.
- Sits between IF and the opcode decoder / EX stage; regfile is external.

Parameters:
- XLEN, 32, datapath width.
- NUM_FWD, 3, number of bypass sources; index 0 = youngest (EX), highest priority.
- RA_W, 5, register address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- stall  in  6  pipeline stall vector; bit1 = IF/ID boundary, bit2 = ID stage.
- flush  in  1  synchronous kill of ID contents.
- if_valid  in  1  IF output valid.
- if_pc  in  XLEN  IF PC.
- inst_sram_rdata  in  32  instruction word, arrives one cycle after its PC.
- rf_raddr1  out  RA_W  regfile read address = rs.
- rf_raddr2  out  RA_W  regfile read address = rt.
- rf_rdata1  in  XLEN  regfile read data for rs.
- rf_rdata2  in  XLEN  regfile read data for rt.
- fwd_we  in  NUM_FWD  per-source write enable.
- fwd_waddr  in  NUM_FWD*RA_W  per-source destination, packed; source i at [i*RA_W +: RA_W].
- fwd_wdata  in  NUM_FWD*XLEN  per-source result, packed likewise.
- fwd_pend  in  NUM_FWD  per-source result not yet available (load in flight).
- stallreq  out  1  hazard stall request.
- id_valid  out  1  ID holds a live instruction.
- id_pc  out  XLEN  PC of the ID instruction.
- id_inst  out  32  stable instruction word.
- id_rs_val  out  XLEN  forwarded rs operand.
- id_rt_val  out  XLEN  forwarded rt operand.
- br_e  out  1  taken branch/jump.
- br_addr  out  XLEN  redirect target.

Behaviour:
- Reset (rst low, asynchronous):
  - stage register {valid, pc} = 0; hold register = 0; FSM = RUN.
  - Outputs: id_valid 0, id_pc 0, id_inst 0, stallreq 0, br_e 0, br_addr 0.
- Stage register update, on posedge clk, first match wins:
  - flush: valid<=0.
  - stall[1] & !stall[2]: valid<=0 (bubble).
  - !stall[1]: {valid, pc}<={if_valid, if_pc}.
  - Otherwise: hold.
  - A flush takes effect in the same edge even when stall[2]=1.
- Instruction hold FSM (states RUN, HOLD):
  - RUN:
    - id_inst = inst_sram_rdata.
    - On an edge with stall[2]=1 & valid=1 & !flush: capture inst_sram_rdata into hold_inst; go to HOLD.
  - HOLD:
    - id_inst = hold_inst.
    - On an edge with stall[2]=0: go to RUN.
    - flush: go to RUN.
  - Invalid stage: id_inst forced to 0 (nop).
- Operand select, combinational, per operand:
  - Address 0 -> value 0.
  - Otherwise the lowest-index source i with fwd_we[i] & fwd_waddr[i]==addr supplies fwd_wdata[i].
  - No such source -> rf_rdata.
- Operand use (from id_inst):
  - use_rs: all except j, jal, sll/srl/sra (immediate shift), lui.
  - use_rt: R-type, beq, bne, stores.
- Hazard / stallreq:
  - stallreq = id_valid & ((use_rs & pend_rs) | (use_rt & pend_rt)).
  - pend_x = the winning-priority matching source has fwd_pend=1.
  - A non-pending younger match masks an older pending one.
- Branch unit:
  - br_e = id_valid & !stallreq & taken.
  - beq/bne: compare forwarded operands; target = pc+4+(sext(imm16)<<2).
  - j/jal: {pc+4[31:28], index, 2'b00}.
  - jr/jalr: id_rs_val.
  - br_addr = 0 when br_e=0.
- Arithmetic: all PC math modulo 2^XLEN; wraps without a flag.
- Simultaneous events: flush beats stall; a stall asserted and released in consecutive cycles leaves exactly one instruction in ID.

Test Plan:
- Reset: assert rst=0 mid-run with valid=1 and FSM in HOLD -> within the same cycle id_valid=0, br_e=0, stallreq=0; after release, FSM=RUN.
- Hold: fetch addiu at pc 0x100, assert stall[2:1]=2'b11 for 3 cycles while rdata changes to 0xDEADBEEF -> id_inst stays the addiu word, id_pc=0x100; after release, the next instruction enters.
- Forward priority: fwd_we=3'b111, all waddr=5, wdata {EX=0x11, MEM=0x22, WB=0x33}, inst uses rs=5 -> id_rs_val=0x11. Drop fwd_we[0] -> 0x22.
- Load-use: fwd_pend[0]=1, waddr0=8, ID inst `addu $9,$8,$10` -> stallreq=1, br_e=0. Clear fwd_pend -> stallreq=0 the same cycle.
- Branch: beq with both operands 7, pc=0x200, imm=0xFFFF -> br_e=1, br_addr=0x200. bne in the same case -> br_e=0, br_addr=0.
- Bubble/flush: stall=6'b000010 -> next cycle id_valid=0. flush with stall[2]=1 -> id_valid=0, FSM=RUN.
